// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV64 control FSM: decode, sequencing, memory wait/timeout handling
module multicycle_control #(
   parameter int WAIT_LIMIT = 255,
   parameter int CNT_W      = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   input  logic        alu_zero,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        reg_write,
   output logic [2:0]  alu_op,
   output logic        alu_src,
   output logic        reg_data_src,
   output logic        retire,
   output logic        illegal,
   output logic        bus_err,
   output logic [3:0]  state_dbg
);

   typedef enum logic [3:0] {
      BOOT   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  EXEC_R = 4'd3,
      EXEC_I = 4'd4,  ADDR   = 4'd5,  MEM_RD = 4'd6,  MEM_WR = 4'd7,
      WB_ALU = 4'd8,  WB_MEM = 4'd9,  BRANCH = 4'd10, TRAP   = 4'd11
   } state_t;

   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);
   localparam logic [2:0] OP_ADD = 3'b111, OP_SUB = 3'b000, OP_AND = 3'b001, OP_OR = 3'b011;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [6:0]       opcode, funct7;
   logic [2:0]       funct3;
   logic             illegal_q, bus_err_q, set_illegal, set_bus_err, latch_ir;
   logic             is_r, r_ok, is_i, is_ld, is_sd, is_beq, wait_hit;
   logic [2:0]       r_alu_op;
   logic             unused_instr_bits;

   assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

   assign is_r   = (opcode == 7'b0110011);
   assign r_ok   = is_r && (((funct3 == 3'b000) && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000))) ||
                            ((funct3 == 3'b111) && (funct7 == 7'b0000000)) ||
                            ((funct3 == 3'b110) && (funct7 == 7'b0000000)));
   assign is_i   = (opcode == 7'b0010011) && (funct3 == 3'b000);
   assign is_ld  = (opcode == 7'b0000011) && (funct3 == 3'b011);
   assign is_sd  = (opcode == 7'b0100011) && (funct3 == 3'b011);
   assign is_beq = (opcode == 7'b1100011) && (funct3 == 3'b000);
   assign wait_hit = (cnt == LIMIT_M1);

   always_comb begin
      unique case (funct3)
         3'b111:  r_alu_op = OP_AND;
         3'b110:  r_alu_op = OP_OR;
         default: r_alu_op = funct7[5] ? OP_SUB : OP_ADD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= BOOT;
         cnt       <= '0;
         opcode    <= '0;
         funct3    <= '0;
         funct7    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (latch_ir) begin
            opcode <= instr[6:0];
            funct3 <= instr[14:12];
            funct7 <= instr[31:25];
         end
         if (set_illegal) illegal_q <= 1'b1;
         if (set_bus_err) bus_err_q <= 1'b1;
      end
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      latch_ir     = 1'b0;
      set_illegal  = 1'b0;
      set_bus_err  = 1'b0;
      imem_req     = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      reg_write    = 1'b0;
      alu_op       = OP_ADD;
      alu_src      = 1'b0;
      reg_data_src = 1'b1;
      retire       = 1'b0;
      unique case (state)
         BOOT: begin
            state_nx = FETCH;
            cnt_nx   = '0;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               latch_ir = 1'b1;
               state_nx = DECODE;
               cnt_nx   = '0;
            end else if (wait_hit) begin
               state_nx    = TRAP;
               set_bus_err = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         DECODE: begin
            if (r_ok)               state_nx = EXEC_R;
            else if (is_i)          state_nx = EXEC_I;
            else if (is_ld | is_sd) state_nx = ADDR;
            else if (is_beq)        state_nx = BRANCH;
            else begin
               state_nx    = TRAP;
               set_illegal = 1'b1;
            end
         end
         EXEC_R: begin
            alu_op   = r_alu_op;
            state_nx = WB_ALU;
         end
         EXEC_I: begin
            alu_src  = 1'b1;
            state_nx = WB_ALU;
         end
         WB_ALU: begin
            // operand select is rebuilt from the latched opcode so the ALU result stays stable
            alu_src   = !is_r;
            alu_op    = is_r ? r_alu_op : OP_ADD;
            reg_write = 1'b1;
            retire    = 1'b1;
            state_nx  = FETCH;
            cnt_nx    = '0;
         end
         ADDR: begin
            alu_src  = 1'b1;
            state_nx = is_ld ? MEM_RD : MEM_WR;
            cnt_nx   = '0;
         end
         MEM_RD, MEM_WR: begin
            alu_src  = 1'b1;
            dmem_req = 1'b1;
            dmem_we  = (state == MEM_WR);
            if (dmem_ack) begin
               retire   = (state == MEM_WR);
               state_nx = (state == MEM_WR) ? FETCH : WB_MEM;
               cnt_nx   = '0;
            end else if (wait_hit) begin
               state_nx    = TRAP;
               set_bus_err = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         WB_MEM: begin
            reg_write    = 1'b1;
            reg_data_src = 1'b0;
            retire       = 1'b1;
            state_nx     = FETCH;
            cnt_nx       = '0;
         end
         BRANCH: begin
            alu_op   = OP_SUB;
            pc_write = alu_zero;
            pc_src   = alu_zero;
            retire   = 1'b1;
            state_nx = FETCH;
            cnt_nx   = '0;
         end
         TRAP: state_nx = TRAP;
         default: state_nx = BOOT;
      endcase
   end

   assign illegal   = illegal_q;
   assign bus_err   = bus_err_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed scoreboard bench for multicycle_control
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic        imem_ack = 1'b0, dmem_ack = 1'b0, alu_zero = 1'b0;
   logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_write;
   logic [2:0]  alu_op;
   logic        alu_src, reg_data_src, retire, illegal, bus_err;
   logic [3:0]  state_dbg;

   always #5 clk = ~clk;

   multicycle_control #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .alu_zero(alu_zero), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
      .alu_op(alu_op), .alu_src(alu_src), .reg_data_src(reg_data_src), .retire(retire),
      .illegal(illegal), .bus_err(bus_err), .state_dbg(state_dbg)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_write;
      logic [2:0] alu_op;
      logic       alu_src, reg_data_src, retire, illegal, bus_err;
   } obs_t;

   obs_t got;
   assign got = {state_dbg, imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_write,
                 alu_op, alu_src, reg_data_src, retire, illegal, bus_err};

   obs_t sb[$];
   int   tests = 0;
   int   fails = 0;
   logic e_ill = 1'b0, e_berr = 1'b0;

   function automatic obs_t base(input logic [3:0] st);
      obs_t o;
      o              = '0;
      o.st           = st;
      o.alu_op       = 3'b111;
      o.reg_data_src = 1'b1;
      o.illegal      = e_ill;
      o.bus_err      = e_berr;
      return o;
   endfunction

   task automatic compare(input string tag);
      obs_t e;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL %s: got=%h but scoreboard empty", tag, got);
      end else begin
         e = sb.pop_front();
         assert (got === e) else begin
            fails++;
            $error("FAIL %s: got=%h exp=%h", tag, got, e);
         end
      end
   endtask

   task automatic step(input logic ia, input logic da, input logic az, input string tag);
      @(posedge clk);
      #1;
      imem_ack = ia;
      dmem_ack = da;
      alu_zero = az;
      @(negedge clk);
      compare(tag);
   endtask

   task automatic apply_reset();
      e_ill  = 1'b0;
      e_berr = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      alu_zero = 1'b0;
      sb.push_back(base(4'd0));
      @(negedge clk);
      compare("reset_hold");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.push_back(base(4'd0));
      @(negedge clk);
      compare("reset_release");
   endtask

   task automatic push_fetch();
      obs_t e;
      e = base(4'd1); e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
      sb.push_back(e);
   endtask

   task automatic run_alu(input logic [31:0] ins, input logic [2:0] aop, input logic imm, input string tag);
      obs_t e;
      instr = ins;
      push_fetch();
      sb.push_back(base(4'd2));
      e = base(imm ? 4'd4 : 4'd3); e.alu_src = imm; e.alu_op = aop;
      sb.push_back(e);
      e = base(4'd8); e.alu_src = imm; e.alu_op = aop; e.reg_write = 1'b1; e.retire = 1'b1;
      sb.push_back(e);
      repeat (4) step(1'b1, 1'b0, 1'b0, tag);
   endtask

   task automatic run_beq(input logic az, input string tag);
      obs_t e;
      instr = 32'h00208463;
      push_fetch();
      sb.push_back(base(4'd2));
      e = base(4'd10); e.alu_op = 3'b000; e.pc_write = az; e.pc_src = az; e.retire = 1'b1;
      sb.push_back(e);
      repeat (3) step(1'b1, 1'b0, az, tag);
   endtask

   initial begin
      obs_t e;
      apply_reset();

      run_alu(32'h002081B3, 3'b111, 1'b0, "add");
      run_alu(32'h402081B3, 3'b000, 1'b0, "sub");
      run_alu(32'h0020F1B3, 3'b001, 1'b0, "and");
      run_alu(32'h0020E1B3, 3'b011, 1'b0, "or");
      run_alu(32'h00108093, 3'b111, 1'b1, "addi");

      // ld with dmem_ack on the fourth request cycle, which is also the wait-limit cycle
      instr = 32'h0080B183;
      push_fetch();
      sb.push_back(base(4'd2));
      e = base(4'd5); e.alu_src = 1'b1; sb.push_back(e);
      repeat (4) begin
         e = base(4'd6); e.alu_src = 1'b1; e.dmem_req = 1'b1; sb.push_back(e);
      end
      e = base(4'd9); e.reg_write = 1'b1; e.reg_data_src = 1'b0; e.retire = 1'b1; sb.push_back(e);
      repeat (3) step(1'b1, 1'b0, 1'b0, "ld");
      repeat (3) step(1'b0, 1'b0, 1'b0, "ld_wait");
      step(1'b0, 1'b1, 1'b0, "ld_ack");
      step(1'b0, 1'b0, 1'b0, "ld_wb");

      instr = 32'h0030B423;
      push_fetch();
      sb.push_back(base(4'd2));
      e = base(4'd5); e.alu_src = 1'b1; sb.push_back(e);
      e = base(4'd7); e.alu_src = 1'b1; e.dmem_req = 1'b1; e.dmem_we = 1'b1; e.retire = 1'b1;
      sb.push_back(e);
      repeat (3) step(1'b1, 1'b0, 1'b0, "sd");
      step(1'b0, 1'b1, 1'b0, "sd_ack");

      run_beq(1'b1, "beq_taken");
      run_beq(1'b0, "beq_not_taken");

      instr = 32'hFFFFFFFF;
      push_fetch();
      sb.push_back(base(4'd2));
      e_ill = 1'b1;
      repeat (3) sb.push_back(base(4'd11));
      repeat (5) step(1'b1, 1'b0, 1'b0, "illegal");

      apply_reset();
      instr = 32'h0;
      repeat (4) begin
         e = base(4'd1); e.imem_req = 1'b1; sb.push_back(e);
      end
      e_berr = 1'b1;
      repeat (2) sb.push_back(base(4'd11));
      repeat (6) step(1'b0, 1'b0, 1'b0, "imem_timeout");

      apply_reset();
      instr = 32'h002081B3;
      repeat (3) begin
         e = base(4'd1); e.imem_req = 1'b1; sb.push_back(e);
      end
      repeat (3) step(1'b0, 1'b0, 1'b0, "imem_wait");
      run_alu(32'h002081B3, 3'b111, 1'b0, "ack_at_limit");

      instr = 32'h0030B423;
      push_fetch();
      sb.push_back(base(4'd2));
      e = base(4'd5); e.alu_src = 1'b1; sb.push_back(e);
      repeat (2) begin
         e = base(4'd7); e.alu_src = 1'b1; e.dmem_req = 1'b1; e.dmem_we = 1'b1; sb.push_back(e);
      end
      repeat (3) step(1'b1, 1'b0, 1'b0, "sd_abort");
      repeat (2) step(1'b0, 1'b0, 1'b0, "sd_abort_wait");
      apply_reset();
      e = base(4'd1); e.imem_req = 1'b1; sb.push_back(e);
      step(1'b0, 1'b0, 1'b0, "refetch");

      tests++;
      assert (sb.size() == 0) else begin
         fails++;
         $error("FAIL sb_drain: got=%0d leftover exp=0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
